// File: rtl/pal_ram_dp_if.sv
`default_nettype none
// ============================================================================
//  Module   : pal_ram_dp_if
//  Purpose  : Bus bundle for the dual-port palette/VRAM store. Port A is the
//             CPU side and port B is the renderer side. The clear control and
//             status signals travel with them.
//  Signals  : clear_req (m->s)        start a full clear while idle
//             busy      (s->m)        clear sequence running
//             wren_x, byteena_x, address_x, data_x (m->s)  port x request
//             q_x       (s->m)        port x registered read data
//  Modports : master (requester side), slave (RAM side)
//  Revision : 1.0  initial release
// ============================================================================
interface pal_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  clear_req;
  logic                  busy;

  logic                  wren_a;
  logic [DATA_W/8-1:0]   byteena_a;
  logic [ADDR_W-1:0]     address_a;
  logic [DATA_W-1:0]     data_a;
  logic [DATA_W-1:0]     q_a;

  logic                  wren_b;
  logic [DATA_W/8-1:0]   byteena_b;
  logic [ADDR_W-1:0]     address_b;
  logic [DATA_W-1:0]     data_b;
  logic [DATA_W-1:0]     q_b;

  modport master (
    output clear_req, wren_a, byteena_a, address_a, data_a,
           wren_b, byteena_b, address_b, data_b,
    input  busy, q_a, q_b
  );

  modport slave (
    input  clear_req, wren_a, byteena_a, address_a, data_a,
           wren_b, byteena_b, address_b, data_b,
    output busy, q_a, q_b
  );
endinterface
`default_nettype wire

// File: rtl/pal_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : pal_ram_dp
//  Purpose  : True dual-port palette/VRAM store with per-byte write enables,
//             registered reads (latency 1 or 2), per-byte write-collision
//             resolution (port A wins) and a built-in clear sequencer that
//             zeroes every word after reset or on request.
//  Ports    : clock    rising-edge clock
//             reset_n  asynchronous active-low reset
//             bus      pal_ram_dp_if.slave (clear control, ports A and B)
//  Revision : 1.0  initial release
// ============================================================================
module pal_ram_dp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int READ_LAT   = 1,
  parameter int B_WRITABLE = 1
) (
  input wire          clock,
  input wire          reset_n,
  pal_ram_dp_if.slave bus
);

  localparam int              c_DEPTH    = 1 << ADDR_W;
  localparam int              c_NBYTES   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_LAST   = '1;

  localparam logic [0:0]      c_ST_CLEAR = 1'b0;
  localparam logic [0:0]      c_ST_IDLE  = 1'b1;

  logic [0:0]          r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [DATA_W-1:0]   r_rd_a;
  logic [DATA_W-1:0]   r_rd_b;

  logic                w_busy;
  logic [c_NBYTES-1:0] w_be_a;
  logic [c_NBYTES-1:0] w_be_b_req;
  logic [c_NBYTES-1:0] w_be_b;

  assign w_busy   = (r_state == c_ST_CLEAR);
  assign bus.busy = w_busy;

  // --------------------------------------------------------------------------
  // Clear sequencer. The counter wraps to 0 on the last word, so re-entry
  // from IDLE only has to clear it explicitly for readability.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        c_ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == c_LAST) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          if (bus.clear_req) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Effective byte enables. User writes are dropped while clearing. When both
  // ports hit the same word, port B only keeps the bytes port A leaves alone.
  // --------------------------------------------------------------------------
  assign w_be_a     = (bus.wren_a && !w_busy) ? bus.byteena_a : '0;
  assign w_be_b_req = ((B_WRITABLE != 0) && bus.wren_b && !w_busy) ? bus.byteena_b : '0;
  assign w_be_b     = (bus.address_a == bus.address_b) ? (w_be_b_req & ~w_be_a) : w_be_b_req;

  // The array is not reset: its contents are only defined once a clear pass
  // has completed.
  always_ff @(posedge clock) begin
    if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end
    for (int k = 0; k < c_NBYTES; k++) begin
      if (w_be_a[k]) begin
        r_mem[bus.address_a][k*8 +: 8] <= bus.data_a[k*8 +: 8];
      end
      if (w_be_b[k]) begin
        r_mem[bus.address_b][k*8 +: 8] <= bus.data_b[k*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // First read stage. Sampling the array with non-blocking semantics gives
  // old-data behaviour for a read and write to the same word in one cycle.
  // Reads issued while clearing return zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= w_busy ? '0 : r_mem[bus.address_a];
      r_rd_b <= w_busy ? '0 : r_mem[bus.address_b];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_out_a;
      logic [DATA_W-1:0] r_out_b;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_out_a <= '0;
          r_out_b <= '0;
        end else begin
          r_out_a <= r_rd_a;
          r_out_b <= r_rd_b;
        end
      end

      assign bus.q_a = r_out_a;
      assign bus.q_b = r_out_b;
    end else begin : g_lat1
      assign bus.q_a = r_rd_a;
      assign bus.q_b = r_rd_b;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pal_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pal_ram_dp
//  Purpose  : Self-checking bench for pal_ram_dp. dut0 uses READ_LAT=1 with a
//             writable port B; dut1 uses READ_LAT=2 with port B read-only.
//             Both see identical stimulus. Expected read data is queued per
//             DUT when the address is presented and popped when due.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pal_ram_dp;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pal_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) bus0 ();
  pal_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) bus1 ();

  pal_ram_dp #(.DATA_W(32), .ADDR_W(8), .READ_LAT(1), .B_WRITABLE(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0.slave));
  pal_ram_dp #(.DATA_W(32), .ADDR_W(8), .READ_LAT(2), .B_WRITABLE(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave));

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic wa, input logic [3:0] bea, input logic [7:0] aa,
                       input logic [31:0] da, input logic wb, input logic [3:0] beb,
                       input logic [7:0] ab, input logic [31:0] db);
    bus0.wren_a = wa; bus0.byteena_a = bea; bus0.address_a = aa; bus0.data_a = da;
    bus0.wren_b = wb; bus0.byteena_b = beb; bus0.address_b = ab; bus0.data_b = db;
    bus1.wren_a = wa; bus1.byteena_a = bea; bus1.address_a = aa; bus1.data_a = da;
    bus1.wren_b = wb; bus1.byteena_b = beb; bus1.address_b = ab; bus1.data_b = db;
  endtask

  task automatic set_clr(input logic c);
    bus0.clear_req = c;
    bus1.clear_req = c;
  endtask

  // Queue an expected read result; the read address must already be driven.
  task automatic expect_rd(input int d, input bit p, input logic [31:0] v, input string nm);
    exp_t e;
    e.due  = cyc + ((d == 0) ? 1 : 2);
    e.port = p;
    e.val  = v;
    e.name = nm;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic logic [31:0] q_of(input int d, input bit p);
    if (d == 0) return p ? bus0.q_b : bus0.q_a;
    return p ? bus1.q_b : bus1.q_a;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    int          n;
    exp_t        e;
    logic [31:0] a;
    reset_n = 1'b0;
    set_clr(1'b0);
    drive(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (busy_of(d) !== 1'b1) begin n_err++; $display("FAIL reset_busy dut%0d: got %b want 1", d, busy_of(d)); end
      n_vec++; if (q_of(d, 0) !== 32'h0) begin n_err++; $display("FAIL reset_q_a dut%0d: got %h want 0", d, q_of(d, 0)); end
      n_vec++; if (q_of(d, 1) !== 32'h0) begin n_err++; $display("FAIL reset_q_b dut%0d: got %h want 0", d, q_of(d, 1)); end
    end
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus0.busy === 1'b1 && n < 300);
    n_vec++; if (n != 256) begin n_err++; $display("FAIL reset_busy_len: got %0d cycles want 256", n); end
    n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_len dut1: busy got %b want 0", bus1.busy); end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(0, 4'h0, 8'hFF, 32'h0, 0, 4'h0, 8'hFF, 32'h0);
        for (int d = 0; d < 2; d++) begin
          expect_rd(d, 0, 32'h0, "post_reset_ff_a");
          expect_rd(d, 1, 32'h0, "post_reset_ff_b");
        end
      end
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_byte_enable();
    exp_t        e;
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1, 4'hF, 8'h10, 32'h11223344, 0, 4'h0, 8'h00, 32'h0);
        1: begin
          drive(1, 4'h5, 8'h10, 32'hAABBCCDD, 0, 4'h0, 8'h00, 32'h0);
          expect_rd(0, 0, 32'h11223344, "be_rdw_same_port");
        end
        2: begin
          drive(0, 4'h0, 8'h11, 32'h0, 0, 4'h0, 8'h00, 32'h0);
          expect_rd(0, 0, 32'h0, "be_other_word");
          expect_rd(1, 0, 32'h0, "be_lat_hold");
        end
        3: begin
          drive(0, 4'h0, 8'h10, 32'h0, 0, 4'h0, 8'h00, 32'h0);
          expect_rd(0, 0, 32'h11BB33DD, "be_merge");
          expect_rd(1, 0, 32'h11BB33DD, "be_merge_lat2");
        end
        default: ;
      endcase
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_collision();
    exp_t        e;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 4'h3, 8'h20, 32'h0000FFFF, 1, 4'hF, 8'h20, 32'h12345678);
        1: begin
          drive(0, 4'h0, 8'h20, 32'h0, 0, 4'h0, 8'h20, 32'h0);
          expect_rd(0, 0, 32'h1234FFFF, "collide_a");
          expect_rd(0, 1, 32'h1234FFFF, "collide_b");
          expect_rd(1, 0, 32'h0000FFFF, "collide_ro_a");
          expect_rd(1, 1, 32'h0000FFFF, "collide_ro_b");
        end
        default: ;
      endcase
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_read_during_write();
    exp_t        e;
    logic [31:0] a;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 4'hF, 8'h30, 32'hCAFEF00D, 0, 4'h0, 8'h00, 32'h0);
        1: begin
          drive(0, 4'h0, 8'h30, 32'h0, 1, 4'hF, 8'h30, 32'h55555555);
          expect_rd(0, 0, 32'hCAFEF00D, "rdw_old");
          expect_rd(1, 0, 32'hCAFEF00D, "rdw_old");
        end
        2: begin
          drive(0, 4'h0, 8'h30, 32'h0, 0, 4'h0, 8'h00, 32'h0);
          expect_rd(0, 0, 32'h55555555, "rdw_new");
          expect_rd(1, 0, 32'hCAFEF00D, "rdw_ro_keep");
        end
        default: ;
      endcase
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_clear();
    int          n;
    exp_t        e;
    logic [31:0] a;
    drive(1, 4'hF, 8'h05, 32'hDEADBEEF, 0, 4'h0, 8'h00, 32'h0);
    tick();
    drive(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    n_vec++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL clear_start dut0: busy got %b want 1", bus0.busy); end
    n_vec++; if (bus1.busy !== 1'b1) begin n_err++; $display("FAIL clear_start dut1: busy got %b want 1", bus1.busy); end
    n = 0;
    while (bus0.busy === 1'b1 && n < 300) begin
      drive(n == 50, 4'hF, (n == 50) ? 8'h05 : ((n == 10) ? 8'h10 : 8'h00), 32'h1,
            0, 4'h0, 8'h00, 32'h0);
      set_clr(n == 100);
      if (n == 10) begin
        expect_rd(0, 0, 32'h0, "clear_read_forced");
        expect_rd(1, 0, 32'h0, "clear_read_forced");
      end
      tick();
      n++;
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
    set_clr(1'b0);
    n_vec++; if (n != 256) begin n_err++; $display("FAIL clear_busy_len: got %0d cycles want 256", n); end
    n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL clear_busy_len dut1: busy got %b want 0", bus1.busy); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        drive(0, 4'h0, 8'h05, 32'h0, 0, 4'h0, 8'h10, 32'h0);
        for (int d = 0; d < 2; d++) begin
          expect_rd(d, 0, 32'h0, "clear_dropped_write");
          expect_rd(d, 1, 32'h0, "clear_zeroed");
        end
      end
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_clear();
    int          n;
    exp_t        e;
    logic [31:0] a;
    drive(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    repeat (100) tick();
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (busy_of(d) !== 1'b1) begin n_err++; $display("FAIL midrst_busy dut%0d: got %b want 1", d, busy_of(d)); end
      n_vec++; if (q_of(d, 0) !== 32'h0) begin n_err++; $display("FAIL midrst_q_a dut%0d: got %h want 0", d, q_of(d, 0)); end
      n_vec++; if (q_of(d, 1) !== 32'h0) begin n_err++; $display("FAIL midrst_q_b dut%0d: got %h want 0", d, q_of(d, 1)); end
    end
    repeat (3) tick();
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus0.busy === 1'b1 && n < 300);
    n_vec++; if (n != 256) begin n_err++; $display("FAIL midrst_busy_len: got %0d cycles want 256", n); end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 4'h0, 8'h00, 32'h0, 1, 4'hF, 8'h40, 32'hFFFFFFFF);
        1: begin
          drive(0, 4'h0, 8'h40, 32'h0, 0, 4'h0, 8'h40, 32'h0);
          expect_rd(0, 0, 32'hFFFFFFFF, "b_write_a");
          expect_rd(0, 1, 32'hFFFFFFFF, "b_write_b");
          expect_rd(1, 0, 32'h0, "b_readonly_a");
          expect_rd(1, 1, 32'h0, "b_readonly_b");
        end
        default: ;
      endcase
      tick();
      while (sb0.size() > 0 && sb0[0].due <= cyc) begin
        e = sb0.pop_front(); a = q_of(0, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut0 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        e = sb1.pop_front(); a = q_of(1, e.port); n_vec++;
        if (a !== e.val) begin n_err++; $display("FAIL %s dut1 port%0d: got %h want %h", e.name, e.port, a, e.val); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_read_during_write();
    test_clear();
    test_reset_mid_clear();
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d/%0d entries want 0/0", sb0.size(), sb1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
